// File: rtl/cbx_io_edge_param_if.sv
// Configuration-chain bundle for cbx_io_edge_param: serial ccff data, shift/commit
// controls and the chain's status flags.
interface cbx_io_edge_param_if;
   logic ccff_head;
   logic ccff_shift_en;
   logic ccff_commit;
   logic ccff_tail;
   logic cfg_ready;
   logic cfg_err;

   modport master (
      output ccff_head, ccff_shift_en, ccff_commit,
      input  ccff_tail, cfg_ready, cfg_err
   );

   modport slave (
      input  ccff_head, ccff_shift_en, ccff_commit,
      output ccff_tail, cfg_ready, cfg_err
   );
endinterface

// File: rtl/cbx_io_edge_param.sv
// Bottom-edge connection block merged with its I/O tile; pad controls come from a
// double-buffered ccff chain. Define CBX_IO_CFG_PARITY_EN to add an even-parity bit per frame.
module cbx_io_edge_param #(
   parameter int CHAN_W = 30,
   parameter int NUM_IO = 4
) (
   input  logic                      prog_clk,
   input  logic                      prog_reset_n,
   cbx_io_edge_param_if.slave        cfg,
   input  logic [CHAN_W-1:0]         chanx_left_in,
   input  logic [CHAN_W-1:0]         chanx_right_in,
   output logic [CHAN_W-1:0]         chanx_left_out,
   output logic [CHAN_W-1:0]         chanx_right_out,
   input  logic                      isol_n,
   input  logic [NUM_IO-1:0]         gfpga_pad_io_soc_in,
   output logic [NUM_IO-1:0]         gfpga_pad_io_soc_out,
   output logic [NUM_IO-1:0]         gfpga_pad_io_soc_dir,
   output logic [NUM_IO-1:0]         inpad
);
   localparam int SEL_W    = $clog2(2 * CHAN_W);
   localparam int FIELD_W  = SEL_W + 2;
   localparam int CFG_BITS = NUM_IO * FIELD_W;
`ifdef CBX_IO_CFG_PARITY_EN
   localparam int FRAME_BITS = CFG_BITS + 1;
`else
   localparam int FRAME_BITS = CFG_BITS;
`endif
   localparam int                 CNT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FRAME_BITS);
   localparam logic [SEL_W:0]     NUM_TRACKS = (SEL_W + 1)'(2 * CHAN_W);

   typedef enum logic [1:0] {EMPTY, LOAD, ARMED, ACTIVE} state_e;

   state_e                 state_q;
   logic [FRAME_BITS-1:0]  sreg_q, sreg_d;
   logic [CFG_BITS-1:0]    shadow_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ready_q, err_q;
   logic                   parity_ok, commit_ok, commit_bad;

   assign chanx_left_out  = chanx_right_in;
   assign chanx_right_out = chanx_left_in;

   assign cfg.ccff_tail = sreg_q[FRAME_BITS-1];
   assign cfg.cfg_ready = ready_q;
   assign cfg.cfg_err   = err_q;

`ifdef CBX_IO_CFG_PARITY_EN
   assign parity_ok = ~^sreg_q;
`else
   assign parity_ok = 1'b1;
`endif

   assign sreg_d     = cfg.ccff_shift_en ? {sreg_q[FRAME_BITS-2:0], cfg.ccff_head} : sreg_q;
   assign cnt_d      = (cfg.ccff_shift_en && cnt_q != CNT_FULL) ? cnt_q + 1'b1 : cnt_q;
   assign commit_ok  = cfg.ccff_commit && state_q == ARMED && !cfg.ccff_shift_en && parity_ok;
   assign commit_bad = cfg.ccff_commit && !commit_ok;

   // NOTE: every register below uses <= so all of them sample pre-edge values together.
   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         state_q  <= EMPTY;
         sreg_q   <= '0;
         shadow_q <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         sreg_q <= sreg_d;
         if (commit_ok) begin
            shadow_q <= sreg_q[FRAME_BITS-1 -: CFG_BITS];
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ACTIVE;
         end else begin
            cnt_q <= cnt_d;
            if (commit_bad) begin
               err_q <= 1'b1;
            end else begin
               case (state_q)
                  EMPTY, ACTIVE: begin
                     if (cfg.ccff_shift_en) state_q <= (cnt_d == CNT_FULL) ? ARMED : LOAD;
                  end
                  LOAD: begin
                     if (cnt_d == CNT_FULL) state_q <= ARMED;
                  end
                  default: state_q <= state_q;
               endcase
            end
         end
      end
   end

   // Track space is {right, left}: sel indexes left first, then right, then reads 0.
   logic [2*CHAN_W-1:0] tracks;
   assign tracks = {chanx_right_in, chanx_left_in};

   // NOTE: each comb output gets a default before the loop so no latch is inferred.
   always_comb begin
      logic [FIELD_W-1:0] field;
      logic [SEL_W-1:0]   sel;
      logic               trk;
      gfpga_pad_io_soc_out = '0;
      gfpga_pad_io_soc_dir = '1;
      inpad                = '0;
      field                = '0;
      sel                  = '0;
      trk                  = 1'b0;
      for (int i = 0; i < NUM_IO; i++) begin
         field = shadow_q[i*FIELD_W +: FIELD_W];
         sel   = field[SEL_W-1:0];
         trk   = ({1'b0, sel} < NUM_TRACKS) ? tracks[sel] : 1'b0;
         gfpga_pad_io_soc_out[i] = isol_n & ready_q & field[SEL_W] & trk;
         gfpga_pad_io_soc_dir[i] = ready_q ? field[SEL_W+1] : 1'b1;
         inpad[i]                = isol_n & gfpga_pad_io_soc_in[i];
      end
   end
endmodule

// File: tb/tb_cbx_io_edge_param.sv
// Scoreboard bench for cbx_io_edge_param at default parameters (CHAN_W=30, NUM_IO=4).
// Pad expectations are queued when stimulus is driven; ccff_tail is checked against a bit-queue model.
module tb_cbx_io_edge_param;
   localparam int CHAN_W   = 30;
   localparam int NUM_IO   = 4;
   localparam int CFG_BITS = 32;
`ifdef CBX_IO_CFG_PARITY_EN
   localparam int FRAME_BITS = CFG_BITS + 1;
`else
   localparam int FRAME_BITS = CFG_BITS;
`endif

   typedef struct {
      string       tag;
      logic [13:0] exp;
   } sb_t;

   logic              prog_clk = 1'b0;
   logic              prog_reset_n;
   logic [CHAN_W-1:0] left_in, right_in, chanx_left_out, chanx_right_out;
   logic              isol_n;
   logic [NUM_IO-1:0] soc_in, soc_out, soc_dir, inpad;

   int   n_checks = 0;
   int   n_fail   = 0;
   sb_t  pad_sb[$];
   logic tail_model[$];

   logic [CFG_BITS-1:0] cur_frame;
   logic                exp_ready, exp_err;

   cbx_io_edge_param_if cfg_if ();

   cbx_io_edge_param #(.CHAN_W(CHAN_W), .NUM_IO(NUM_IO)) dut (
      .prog_clk             (prog_clk),
      .prog_reset_n         (prog_reset_n),
      .cfg                  (cfg_if),
      .chanx_left_in        (left_in),
      .chanx_right_in       (right_in),
      .chanx_left_out       (chanx_left_out),
      .chanx_right_out      (chanx_right_out),
      .isol_n               (isol_n),
      .gfpga_pad_io_soc_in  (soc_in),
      .gfpga_pad_io_soc_out (soc_out),
      .gfpga_pad_io_soc_dir (soc_dir),
      .inpad                (inpad)
   );

   always #5 prog_clk = ~prog_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] fld(input logic dir, input logic en, input logic [5:0] sel);
      return {dir, en, sel};
   endfunction

   function automatic logic [FRAME_BITS-1:0] make_frame(input logic [CFG_BITS-1:0] f);
`ifdef CBX_IO_CFG_PARITY_EN
      return {f, ^f};
`else
      return f;
`endif
   endfunction

   function automatic logic [13:0] expect_vec();
      logic [3:0]        o, d, p;
      logic [7:0]        f;
      logic [5:0]        s;
      logic [CHAN_W-1:0] sh;
      logic              t;
      for (int i = 0; i < NUM_IO; i++) begin
         f = cur_frame[i*8 +: 8];
         s = f[5:0];
         if (s < 6'd30) begin
            sh = left_in >> s;
            t  = sh[0];
         end else if (s < 6'd60) begin
            sh = right_in >> (s - 6'd30);
            t  = sh[0];
         end else begin
            t = 1'b0;
         end
         o[i] = isol_n & exp_ready & f[6] & t;
         d[i] = exp_ready ? f[7] : 1'b1;
         p[i] = isol_n & soc_in[i];
      end
      return {o, d, p, exp_ready, exp_err};
   endfunction

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic pads_fixed(input string tag, input logic [CHAN_W-1:0] l,
                             input logic [CHAN_W-1:0] r, input logic [NUM_IO-1:0] s);
      sb_t e;
      left_in  = l;
      right_in = r;
      soc_in   = s;
      pad_sb.push_back('{tag, expect_vec()});
      #2;
      check({tag, "/left_out"}, 64'(chanx_left_out), 64'(r));
      check({tag, "/right_out"}, 64'(chanx_right_out), 64'(l));
      while (pad_sb.size() > 0) begin
         e = pad_sb.pop_front();
         check(e.tag, 64'({soc_out, soc_dir, inpad, cfg_if.cfg_ready, cfg_if.cfg_err}), 64'(e.exp));
      end
   endtask

   task automatic pads_rand(input string tag);
      pads_fixed(tag, CHAN_W'($urandom), CHAN_W'($urandom), NUM_IO'($urandom));
   endtask

   task automatic shift_bit(input logic b);
      cfg_if.ccff_head     = b;
      cfg_if.ccff_shift_en = 1'b1;
      check("tail", 64'(cfg_if.ccff_tail), 64'(tail_model[0]));
      void'(tail_model.pop_front());
      tail_model.push_back(b);
      tick();
   endtask

   task automatic shift_frame(input logic [FRAME_BITS-1:0] f, input int first, input int n);
      for (int k = first; k < first + n; k++) shift_bit(f[FRAME_BITS-1-k]);
      cfg_if.ccff_shift_en = 1'b0;
   endtask

   task automatic commit(input logic with_shift, input logic b);
      cfg_if.ccff_commit = 1'b1;
      if (with_shift) begin
         cfg_if.ccff_head     = b;
         cfg_if.ccff_shift_en = 1'b1;
         check("tail_commit", 64'(cfg_if.ccff_tail), 64'(tail_model[0]));
         void'(tail_model.pop_front());
         tail_model.push_back(b);
      end
      tick();
      cfg_if.ccff_commit   = 1'b0;
      cfg_if.ccff_shift_en = 1'b0;
   endtask

   task automatic clear_model();
      tail_model.delete();
      for (int k = 0; k < FRAME_BITS; k++) tail_model.push_back(1'b0);
      cur_frame = '0;
      exp_ready = 1'b0;
      exp_err   = 1'b0;
   endtask

   logic [CFG_BITS-1:0]   fa, fb, fc, fd, fe;
   logic [FRAME_BITS-1:0] bad;

   initial begin
      fa = {fld(1, 0, 0), fld(1, 0, 0), fld(1, 0, 0), fld(0, 1, 5)};
      fb = {fld(1, 0, 0), fld(1, 0, 0), fld(0, 1, 40), fld(0, 1, 5)};
      fc = {fld(1, 0, 0), fld(1, 0, 0), fld(0, 1, 62), fld(0, 1, 5)};
      fd = {fld(1, 1, 0), fld(0, 1, 59), fld(0, 1, 29), fld(1, 0, 3)};
      fe = $urandom;

      cfg_if.ccff_head     = 1'b0;
      cfg_if.ccff_shift_en = 1'b0;
      cfg_if.ccff_commit   = 1'b0;
      isol_n   = 1'b1;
      left_in  = '0;
      right_in = '0;
      soc_in   = '0;

      // Reset state
      prog_reset_n = 1'b0;
      clear_model();
      #3;
      check("rst_soc_out", 64'(soc_out), 64'h0);
      check("rst_soc_dir", 64'(soc_dir), 64'hF);
      check("rst_ready", 64'(cfg_if.cfg_ready), 64'h0);
      check("rst_err", 64'(cfg_if.cfg_err), 64'h0);
      check("rst_tail", 64'(cfg_if.ccff_tail), 64'h0);
      pads_rand("rst_pads");
      #20;
      prog_reset_n = 1'b1;
      tick();

      // Frame A: pad0 routes left[5]
      shift_frame(make_frame(fa), 0, FRAME_BITS);
      commit(1'b0, 1'b0);
      cur_frame = fa;
      exp_ready = 1'b1;
      check("a_soc_dir", 64'(soc_dir), 64'hE);
      check("a_ready", 64'(cfg_if.cfg_ready), 64'h1);
      pads_fixed("a_left5_hi", 30'h20, 30'h0, 4'h0);
      check("a_out0_hi", 64'(soc_out), 64'h1);
      pads_fixed("a_left5_lo", 30'h3FFF_FFDF, 30'h3FFF_FFFF, 4'h0);
      for (int k = 0; k < 4; k++) pads_rand("a_rand");

      // Frame B: pad1 sel=40 -> right[10]
      shift_frame(make_frame(fb), 0, FRAME_BITS);
      commit(1'b0, 1'b0);
      cur_frame = fb;
      pads_fixed("b_right10", 30'h0, 30'h400, 4'h0);
      check("b_out_right10", 64'(soc_out), 64'h2);
      for (int k = 0; k < 4; k++) pads_rand("b_rand");

      // Frame C: pad1 sel=62 is out of range
      shift_frame(make_frame(fc), 0, FRAME_BITS);
      commit(1'b0, 1'b0);
      cur_frame = fc;
      pads_fixed("c_sel62", 30'h3FFF_FFFF, 30'h3FFF_FFFF, 4'hF);
      check("c_out_sel62", 64'(soc_out), 64'h1);

      // Rejected commits: partial frame, then shift_en high
      shift_frame(make_frame(fd), 0, 20);
      commit(1'b0, 1'b0);
      exp_err = 1'b1;
      pads_rand("rej_partial");
      shift_frame(make_frame(fd), 20, FRAME_BITS - 20);
      commit(1'b1, 1'b1);
      pads_rand("rej_shift_en");
      check("rej_soc_dir", 64'(soc_dir), 64'hC);

      // Window slides while ARMED; a full frame then commits cleanly
      shift_frame(make_frame(fd), 0, FRAME_BITS);
      commit(1'b0, 1'b0);
      cur_frame = fd;
      exp_err   = 1'b0;
      check("d_err_clear", 64'(cfg_if.cfg_err), 64'h0);
      pads_fixed("d_sel59", 30'h0, 30'h2000_0000, 4'h0);
      pads_fixed("d_sel29", 30'h2000_0000, 30'h0, 4'h0);
      for (int k = 0; k < 3; k++) pads_rand("d_rand");

      // Old config stays live while a new frame shifts; tail replays the old frame
      shift_frame(make_frame(fe), 0, 16);
      pads_rand("e_mid_shift");
      shift_frame(make_frame(fe), 16, FRAME_BITS - 16);
      pads_rand("e_armed_old_cfg");
      commit(1'b0, 1'b0);
      cur_frame = fe;
      for (int k = 0; k < 4; k++) pads_rand("e_rand");

      // Isolation
      isol_n = 1'b0;
      pads_fixed("isol_lo", 30'h3FFF_FFFF, 30'h3FFF_FFFF, 4'hF);
      check("isol_out", 64'(soc_out), 64'h0);
      check("isol_inpad", 64'(inpad), 64'h0);
      isol_n = 1'b1;
      pads_fixed("isol_hi", 30'h3FFF_FFFF, 30'h3FFF_FFFF, 4'hF);
      check("isol_hi_inpad", 64'(inpad), 64'hF);

      // Reset after 17 shifts
      shift_frame(make_frame(fa), 0, 17);
      #2;
      prog_reset_n = 1'b0;
      clear_model();
      #1;
      check("mid_rst_ready", 64'(cfg_if.cfg_ready), 64'h0);
      check("mid_rst_dir", 64'(soc_dir), 64'hF);
      check("mid_rst_tail", 64'(cfg_if.ccff_tail), 64'h0);
      #1;
      prog_reset_n = 1'b1;
      tick();
      pads_rand("post_rst");
      commit(1'b0, 1'b0);
      exp_err = 1'b1;
      pads_rand("empty_commit");

      shift_frame(make_frame(fa), 0, FRAME_BITS);
      commit(1'b0, 1'b0);
      cur_frame = fa;
      exp_ready = 1'b1;
      exp_err   = 1'b0;
      pads_rand("recover");

`ifdef CBX_IO_CFG_PARITY_EN
      bad = make_frame(fb);
      bad[0] = ~bad[0];
      shift_frame(bad, 0, FRAME_BITS);
      commit(1'b0, 1'b0);
      exp_err = 1'b1;
      pads_rand("bad_parity");
      shift_frame(make_frame(fb), 0, FRAME_BITS);
      commit(1'b0, 1'b0);
      cur_frame = fb;
      exp_err   = 1'b0;
      pads_rand("good_parity");
`else
      bad = '0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
